// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl
//   Miss engine between the 4-way data cache and word-wide main memory.
//   On a cacheable miss it stalls the CPU and writes back a dirty victim
//   line (4 beats). It then fetches the missing line (4 beats), packs the
//   beats into MM_data_in and pulses update for one cycle. Accesses at or
//   above IO_BASE are left to the cache.
//
// Ports
//   CLK, RESET          clock; asynchronous active-high reset
//   miss, address       cache miss flag and CPU access address
//   victim_dirty/addr/data  LRU victim state, line address and contents
//   stall               freeze CPU (combinational)
//   update, MM_data_in  install strobe and assembled fill line
//   mem_req/we/addr/wdata  registered memory beat request
//   mem_rdata, mem_ack  memory read data and beat completion
//
// Optional build macro: DCACHE_MISS_STATS_EN adds the miss_count and
// wb_count outputs.
module dcache_miss_ctrl #(
  parameter logic [31:0] IO_BASE    = 32'h1100_0000,
  parameter int          LINE_WORDS = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         miss,
  input  logic [31:0]  address,
  input  logic         victim_dirty,
  input  logic [31:0]  victim_addr,
  input  logic [127:0] victim_data,
  output logic         stall,
  output logic         update,
  output logic [127:0] MM_data_in,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
`ifdef DCACHE_MISS_STATS_EN
  output logic [31:0]  miss_count,
  output logic [31:0]  wb_count,
`endif
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_UPDATE, S_DONE
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  fill_addr_q, fill_addr_d;
  logic [31:0]  wb_addr_q, wb_addr_d;
  logic [127:0] wb_line_q, wb_line_d;
  logic [127:0] fill_line_q, fill_line_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  mem_wdata_q, mem_wdata_d;

  logic         start;
  logic         beat_ack;
  logic [1:0]   cnt_inc;
  logic [31:0]  line_base;

  // Line offset bits never matter: fills are always line aligned.
  logic unused_addr_lo;
  assign unused_addr_lo = ^address[3:0];

  // Word 0 lives in the most significant slot of a line.
  function automatic logic [31:0] line_word(input logic [127:0] l,
                                            input logic [1:0]   i);
    logic [31:0] w;
    w = l[127:96];
    case (i)
      2'd0: w = l[127:96];
      2'd1: w = l[95:64];
      2'd2: w = l[63:32];
      2'd3: w = l[31:0];
      default: w = l[127:96];
    endcase
    return w;
  endfunction

  function automatic logic [127:0] line_put(input logic [127:0] l,
                                            input logic [1:0]   i,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = l;
    case (i)
      2'd0: r[127:96] = w;
      2'd1: r[95:64]  = w;
      2'd2: r[63:32]  = w;
      2'd3: r[31:0]   = w;
      default: r = l;
    endcase
    return r;
  endfunction

  assign start     = (state_q == S_IDLE) && miss && (address < IO_BASE);
  assign beat_ack  = mem_req_q && mem_ack;   // stray acks are ignored
  assign cnt_inc   = cnt_q + 2'd1;
  assign line_base = {address[31:4], 4'b0000};

  // Stall must be up in the very cycle the miss is seen, hence the
  // combinational start term.
  assign stall      = start || (state_q != S_IDLE);
  assign update     = (state_q == S_UPDATE);
  assign MM_data_in = fill_line_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_addr_d = fill_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_line_d   = wb_line_q;
    fill_line_d = fill_line_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fill_addr_d = line_base;
          cnt_d       = 2'd0;
          mem_req_d   = 1'b1;
          if (victim_dirty) begin
            wb_addr_d   = victim_addr;
            wb_line_d   = victim_data;
            mem_we_d    = 1'b1;
            mem_addr_d  = victim_addr;
            mem_wdata_d = victim_data[127:96];
            state_d     = S_WB;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = line_base;
            state_d     = S_FILL;
          end
        end
      end

      S_WB: begin
        if (beat_ack) begin
          if (cnt_q == LAST_BEAT) begin
            // Go straight into the fill with mem_req still high.
            cnt_d      = 2'd0;
            mem_we_d   = 1'b0;
            mem_addr_d = fill_addr_q;
            state_d    = S_FILL;
          end else begin
            cnt_d       = cnt_inc;
            mem_addr_d  = wb_addr_q + {28'd0, cnt_inc, 2'b00};
            mem_wdata_d = line_word(wb_line_q, cnt_inc);
          end
        end
      end

      S_FILL: begin
        if (beat_ack) begin
          fill_line_d = line_put(fill_line_q, cnt_q, mem_rdata);
          if (cnt_q == LAST_BEAT) begin
            cnt_d     = 2'd0;
            mem_req_d = 1'b0;
            state_d   = S_UPDATE;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = fill_addr_q + {28'd0, cnt_inc, 2'b00};
          end
        end
      end

      S_UPDATE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;   // miss is deliberately not sampled here
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_line_q   <= '0;
      fill_line_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_addr_q <= fill_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_line_q   <= wb_line_d;
      fill_line_q <= fill_line_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef DCACHE_MISS_STATS_EN
  logic [31:0] miss_count_q, wb_count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if (start)                miss_count_q <= miss_count_q + 32'd1;
      if (start && victim_dirty) wb_count_q  <= wb_count_q + 32'd1;
    end
  end

  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`endif

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Miss-handling engine directly downstream of the 4-way data cache; sits between the cache and word-wide main memory.
- On a cacheable miss it stalls the CPU and writes back the dirty victim line, 4 words.
- It then fetches the missing line, 4 words, packs it into the 128-bit fill bus and pulses the cache's update strobe.
- IO-space accesses are never serviced here; the cache handles them directly.

Parameters:
- IO_BASE, 32'h11000000, addresses >= this are IO space and never start a miss sequence.
- LINE_WORDS, 4, words per line; fixed by the cache geometry; only 4 is supported.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- miss  in  1  cache miss flag, valid when read|write is asserted.
- address  in  32  CPU access address.
- victim_dirty  in  1  selected LRU victim is valid and dirty.
- victim_addr  in  32  line address of victim, {tag,index,4'b0}.
- victim_data  in  128  victim line; word0 in [127:96].
- stall  out  1  freeze CPU pipeline.
- update  out  1  one-cycle strobe; cache installs MM_data_in.
- MM_data_in  out  128  assembled fill line; word0 in [127:96]; drives the cache.
- mem_req  out  1  main-memory request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  32  word address of current beat.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  beat complete.

Behaviour:
- Reset, asynchronous and immediate:
  - State is IDLE and the beat counter is 0.
  - stall, update, mem_req and mem_we are 0.
  - mem_addr, mem_wdata and MM_data_in are 0.
  - Latched addresses are 0.
  - A reset mid-sequence aborts it and discards partial fill data; no update is issued.
- States: IDLE, WB, FILL, UPDATE, DONE.
- IDLE:
  - Start condition is miss && address < IO_BASE.
  - On start: latch fill_addr = {address[31:4],4'b0}.
  - If victim_dirty, also latch wb_addr and wb_line, then go to WB; otherwise go to FILL. The beat counter is cleared either way.
  - stall is combinational: high in the start cycle and in every non-IDLE state.
- Beat handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until mem_ack is sampled high.
  - Each ack increments the counter (2-bit, wraps 3->0).
  - The next beat's address/data appear the following cycle with mem_req still high; zero wait states are allowed.
  - mem_ack while mem_req=0 is ignored.
- WB:
  - mem_we=1; mem_addr = wb_addr + 4*cnt.
  - mem_wdata = wb_line[127-32*cnt -: 32].
  - Ack on cnt==3 goes to FILL with cnt=0.
- FILL:
  - mem_we=0; mem_addr = fill_addr + 4*cnt.
  - On ack, mem_rdata is written to MM_data_in[127-32*cnt -: 32].
  - Ack on cnt==3 goes to UPDATE; mem_req drops.
- UPDATE: update=1 for exactly one cycle, MM_data_in stable; then DONE.
- DONE:
  - One cycle for the cache hit to settle; stall still high.
  - Then IDLE; stall low the next cycle.
  - miss is not re-evaluated in DONE.
- The inputs miss, address and victim_* are ignored outside IDLE; a change mid-sequence has no effect.
- Latency with zero-wait ack, start cycle T:
  - Clean miss: FILL beats T+1..T+4, update T+5, DONE T+6, stall low T+7.
  - Dirty miss: add 4 cycles.
- MM_data_in holds its value until the next FILL overwrites it.

Optional Feature:
- Macro: DCACHE_MISS_STATS_EN.
- When defined:
  - Add outputs miss_count[31:0] and wb_count[31:0].
  - miss_count increments at each IDLE start; wb_count increments on WB entry.
  - Both are reset to 0 asynchronously and wrap at 2^32.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Clean read miss at 0x00000120, memory returns 0xA0,0xA1,0xA2,0xA3 with zero-wait ack:
  - Read beats at 0x120/124/128/12C.
  - update at T+5 with MM_data_in = {A0,A1,A2,A3}.
  - stall low at T+7.
- Dirty miss, victim_addr 0x00000340, victim_data {11,22,33,44}, then fill at 0x00000500:
  - Four writes 0x340..0x34C carrying 11,22,33,44.
  - Then four reads 0x500..0x50C; exactly one update pulse.
- Memory with 3-wait-state ack:
  - mem_addr/mem_wdata stay stable while mem_req is high and no ack.
  - Total clean-miss stall = 4*4+2+1 cycles.
- miss with address 0x11000004 (IO space): state stays IDLE; stall, mem_req and update stay 0.
- RESET asserted during the 2nd FILL beat:
  - Outputs go to 0 immediately; no update is issued.
  - A subsequent miss restarts the fill from beat 0.
- DCACHE_MISS_STATS_EN defined, 3 misses of which 1 dirty: miss_count=3, wb_count=1; both are 0 after RESET.
